// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage plus a registered carry loop, LSB first.
// Produces {c_out, sum} = a + b + cin after WIDTH RUN cycles.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_c;
  logic             c_c;
  logic             load_c;
  logic             last_c;

  // Single full-adder stage on the current LSBs.
  assign s_c    = shift_a[0] ^ shift_b[0] ^ carry;
  assign c_c    = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
  assign load_c = start && ((state == IDLE) || (state == DONE));
  assign last_c = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, status and datapath registers; sum bits refill shift_a from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      shift_a <= '0;
      shift_b <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      if (load_c) begin
        shift_a <= a;
        shift_b <= b;
        carry   <= cin;
        cnt     <= '0;
      end else if (state == RUN) begin
        shift_a <= {s_c, shift_a[WIDTH-1:1]};
        shift_b <= {1'b0, shift_b[WIDTH-1:1]};
        carry   <= c_c;
        if (last_c) begin
          cnt   <= '0;
          sum   <= {s_c, shift_a[WIDTH-1:1]};
          c_out <= c_c;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: expected results come from plain a + b + cin.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] prev = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if ({c_out, sum} !== 9'h000) begin errors++; $display("FAIL reset_sum: got %h expected 000", {c_out, sum}); end
    rst = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_op: got busy=%b expected 0", busy); end
    prev = '0;
  endtask

  // Single operations from IDLE with junk start/operands driven throughout RUN.
  task automatic test_arith;
    logic [WIDTH-1:0] da [4] = '{8'h35, 8'hFF, 8'hFF, 8'h10};
    logic [WIDTH-1:0] db [4] = '{8'h4A, 8'h01, 8'hFF, 8'h20};
    logic             dc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] oa, ob;
    logic             oc;
    logic [WIDTH:0]   exp;
    for (int n = 0; n < 24; n++) begin
      if (n < 4) begin
        oa = da[n]; ob = db[n]; oc = dc[n];
      end else begin
        oa = WIDTH'($urandom); ob = WIDTH'($urandom); oc = 1'($urandom);
      end
      exp = {1'b0, oa} + {1'b0, ob} + {{WIDTH{1'b0}}, oc};
      a = oa; b = ob; cin = oc; start = 1'b1;
      tick();
      for (int i = 0; i < int'(WIDTH); i++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++; $display("FAIL run_flags op%0d cyc%0d: got busy=%b done=%b expected 1/0", n, i, busy, done);
        end
        checks++;
        if ({c_out, sum} !== prev) begin
          errors++; $display("FAIL run_hold op%0d cyc%0d: got %h expected %h", n, i, {c_out, sum}, prev);
        end
        start = (n >= 3) ? 1'($urandom) : 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        tick();
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL done_flags op%0d: got busy=%b done=%b expected 0/1", n, busy, done);
      end
      checks++;
      if ({c_out, sum} !== exp) begin
        errors++; $display("FAIL result op%0d %h+%h+%b: got %h expected %h", n, oa, ob, oc, {c_out, sum}, exp);
      end
      prev = exp;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {c_out, sum} !== prev) begin
        errors++; $display("FAIL idle_after op%0d: got busy=%b done=%b sum=%h expected 0/0/%h", n, busy, done, {c_out, sum}, prev);
      end
    end
  endtask

  task automatic test_abort;
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy cyc%0d: got %b expected 1", i, busy); end
      if (i < 3) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {c_out, sum} !== 9'h000) begin
      errors++; $display("FAIL abort_reset: got busy=%b done=%b sum=%h expected 0/0/000", busy, done, {c_out, sum});
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_no_done cyc%0d: got busy=%b done=%b expected 0/0", i, busy, done);
      end
    end
    prev = '0;
  endtask

  // Chain of operations, each next start asserted during the previous DONE cycle.
  task automatic test_back_to_back;
    logic [WIDTH-1:0] oa, ob;
    logic             oc;
    logic [WIDTH:0]   exp;
    oa = 8'h01; ob = 8'h02; oc = 1'b0;
    a = oa; b = ob; cin = oc; start = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp = {1'b0, oa} + {1'b0, ob} + {{WIDTH{1'b0}}, oc};
      start = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || {c_out, sum} !== prev) begin
          errors++; $display("FAIL b2b_run op%0d cyc%0d: got busy=%b done=%b sum=%h expected 1/0/%h", k, i, busy, done, {c_out, sum}, prev);
        end
        start = 1'($urandom);
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || {c_out, sum} !== exp) begin
        errors++; $display("FAIL b2b_result op%0d %h+%h+%b: got done=%b sum=%h expected 1/%h", k, oa, ob, oc, done, {c_out, sum}, exp);
      end
      prev = exp;
      if (k == 0) begin
        oa = 8'h80; ob = 8'h80; oc = 1'b0;
      end else begin
        oa = WIDTH'($urandom); ob = WIDTH'($urandom); oc = 1'($urandom);
      end
      if (k < 5) begin
        a = oa; b = ob; cin = oc; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_arith();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder built around the team's 1-bit full adder (sum = a^b^cin, carry = majority(a,b,cin)), one bit per clock, LSB first.
- The single full-adder stage feeds a registered carry loop and a result shift register, turning WIDTH-bit parallel operands into a WIDTH-bit sum plus carry-out.
- Sits downstream of the full adder as its sequential consumer: low-area addition where latency is acceptable.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2).
- CW, $clog2(WIDTH+1), bit counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request: capture a, b, cin and begin addition
- a  input  WIDTH  operand A, sampled only when start is accepted
- b  input  WIDTH  operand B, sampled only when start is accepted
- cin  input  1  carry-in, sampled only when start is accepted
- busy  output  1  high while an addition is in progress (RUN state)
- done  output  1  single-cycle pulse: sum/c_out just updated
- sum  output  WIDTH  registered result of last completed addition
- c_out  output  1  registered carry-out of last completed addition

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, sum=0, c_out=0, counter=0, internal shift registers and carry=0. Reset overrides start.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge E is accepted.
  - Load shift_a<=a, shift_b<=b, carry<=cin, acc<=0, cnt<=0.
  - Move to RUN.
- RUN: each edge computes s = shift_a[0]^shift_b[0]^carry and c = majority(shift_a[0],shift_b[0],carry).
  - Shift shift_a and shift_b right by one.
  - Shift s into acc MSB (acc <= {s, acc[WIDTH-1:1]}).
  - Update carry<=c and cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, which is edge E+WIDTH:
    - Process the last bit.
    - Load sum<={s, acc[WIDTH-1:1]} and c_out<=c.
    - Move to DONE.
- DONE: lasts exactly one cycle, with done=1 during it.
  - With no start, next state is IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation; the next state is RUN.
- busy=1 exactly in RUN, i.e. WIDTH cycles. done=1 exactly in DONE. Both are registered, with no combinational path from inputs.
- Latency: start accepted at edge E, so done is high in the cycle after edge E+WIDTH. With WIDTH=8, done is in the cycle after edge E+8.
- start while busy=1 is ignored. The in-flight operation is unaffected, and a, b and cin changes are ignored.
- sum/c_out hold the previous result throughout RUN and change only on the completing edge. They are stable until the next completion or reset.
- Arithmetic is unsigned modulo 2^WIDTH, with the overflow bit in c_out: {c_out,sum} = a + b + cin.
- Reset mid-RUN aborts the operation. All outputs return to reset values and no done pulse is produced.
- The counter never exceeds WIDTH-1, and there are no illegal states: the state encoding default goes to IDLE.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=8'h00, c_out=0; no operation begins.
- Basic add, WIDTH=8: a=8'h35, b=8'h4A, cin=0, start pulse -> busy high 8 cycles, done pulse 1 cycle later, sum=8'h7F, c_out=0.
- Carry chain and wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, c_out=1.
- Max plus carry-in: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, c_out=1.
- Ignore and abort: during a run of 8'h10+8'h20, change a/b and pulse start mid-RUN -> result sum=8'h30, c_out=0.
  - Then start 8'hAA+8'h55 and assert rst on the 4th RUN cycle -> no done pulse, sum=8'h00, c_out=0.
- Back-to-back: assert start during the DONE cycle of 8'h01+8'h02 (sum=8'h03) with a=8'h80, b=8'h80, cin=0.
  - Required: busy rises in the very next cycle, sum stays 8'h03 until the next completion, then sum=8'h00, c_out=1.
  - Checker compares every completion against a+b+cin.
